fifo_mem_writer: RTL and testbench

//  Drains the accelerator result FIFO into data memory over an OBI-style req/gnt/rvalid port.

---
 rtl/acc_pkg.sv | 22 ++
 rtl/fifo_mem_writer.sv | 206 ++++++++++++++++++++
 tb/tb_fifo_mem_writer.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/acc_pkg.sv
// Shared definitions for the accelerator result path.
//
// Contents:
//   writer_state_e - state encoding of the FIFO-to-memory writer
//   OBI_BE_ALL     - byte enable for a full-word OBI write
//   FIFO_DEPTH     - depth of the accelerator result FIFO; also the writer's
//                    default maximum burst length
package acc_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_FULL = 3'd1,
    POP       = 3'd2,
    LOAD      = 3'd3,
    REQ       = 3'd4,
    WAIT_RV   = 3'd5
  } writer_state_e;

  localparam logic [3:0] OBI_BE_ALL = 4'hF;
  localparam int         FIFO_DEPTH = 16;

endpackage

// File: rtl/fifo_mem_writer.sv
// fifo_mem_writer
//
// Drains the accelerator result FIFO into data memory over an OBI-style
// req/gnt/rvalid port. For every burst it programs the FIFO threshold
// (fifo_count_ext), waits for fifo_full, then pops and writes one word at a
// time to consecutive word addresses with exactly one write outstanding.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   start           1-cycle pulse; latches base_addr/num_words (ignored while busy)
//   base_addr       first write address (bits[1:0] forced to 0)
//   num_words       total number of words to write
//   busy            high from the cycle after an accepted start until done
//   done            1-cycle pulse after the last write response
//   fifo_count_ext  burst threshold to FIFO = min(BURST_MAX, words remaining)
//   fifo_pop        FIFO pop strobe; fifo_dout is valid the following cycle
//   fifo_dout       FIFO registered output
//   fifo_full       FIFO count == fifo_count_ext
//   fifo_empty      FIFO count == 0
//   data_req/gnt/rvalid/we/be/addr/wdata   OBI write master port
//   stall_cnt       cycles with data_req high and data_gnt low
//
// Configuration:
//   STALL_CNT_EN    when defined, stall_cnt is a saturating 32-bit counter
//                   cleared on each accepted start; otherwise it is tied to 0.
module fifo_mem_writer
  import acc_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int BURST_MAX = FIFO_DEPTH,
  parameter int LEN_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  num_words,
  output logic              busy,
  output logic              done,
  output logic [4:0]        fifo_count_ext,
  output logic              fifo_pop,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              fifo_full,
  input  logic              fifo_empty,
  output logic              data_req,
  input  logic              data_gnt,
  input  logic              data_rvalid,
  output logic              data_we,
  output logic [3:0]        data_be,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  output logic [31:0]       stall_cnt
);

  writer_state_e     state_q, state_d;
  logic [LEN_W-1:0]  remaining_q;
  logic [LEN_W-1:0]  remaining_dec;
  logic [4:0]        burst_left_q;
  logic [4:0]        count_ext_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              done_q;
  logic              done_set;
  logic              accept;
  logic              enter_wait_full;
  logic [LEN_W-1:0]  reload_src;
  logic [4:0]        burst_reload;

  // A start landing on the done cycle is dropped so a new transfer never
  // overlaps the completion pulse of the previous one.
  assign accept        = start && (state_q == IDLE) && !done_q;
  assign remaining_dec = remaining_q - LEN_W'(1);

  // The burst threshold is recomputed from whatever is still to be written
  // at the moment WAIT_FULL is entered: the fresh length when leaving IDLE,
  // or the post-decrement count when a burst has just completed.
  assign reload_src      = (state_q == IDLE) ? num_words : remaining_dec;
  assign burst_reload    = (reload_src >= LEN_W'(BURST_MAX)) ? 5'(BURST_MAX)
                                                             : reload_src[4:0];
  assign enter_wait_full = (state_d == WAIT_FULL) && (state_q != WAIT_FULL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus the Moore-style strobes. A pop is only issued when the
  // FIFO reports data, otherwise POP waits so no word is ever fabricated.
  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    data_req = 1'b0;
    done_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (num_words != '0) begin
            state_d = WAIT_FULL;
          end else begin
            done_set = 1'b1;
          end
        end
      end
      WAIT_FULL: begin
        if (fifo_full) begin
          state_d = POP;
        end
      end
      POP: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        state_d = REQ;
      end
      REQ: begin
        data_req = 1'b1;
        if (data_gnt) begin
          state_d = WAIT_RV;
        end
      end
      WAIT_RV: begin
        if (data_rvalid) begin
          if (remaining_q == LEN_W'(1)) begin
            state_d  = IDLE;
            done_set = 1'b1;
          end else if (burst_left_q == 5'd1) begin
            state_d = WAIT_FULL;
          end else begin
            state_d = POP;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath: address/length latch, per-response bookkeeping, burst reload
  // (placed last so it overrides the burst_left decrement on the same edge)
  // and capture of the popped word one cycle after the pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining_q  <= '0;
      burst_left_q <= '0;
      count_ext_q  <= 5'(BURST_MAX);
      addr_q       <= '0;
      wdata_q      <= '0;
      done_q       <= 1'b0;
    end else begin
      done_q <= done_set;
      if (accept) begin
        addr_q      <= base_addr & ~ADDR_W'(3);
        remaining_q <= num_words;
      end
      if (state_q == LOAD) begin
        wdata_q <= fifo_dout;
      end
      if ((state_q == WAIT_RV) && data_rvalid) begin
        addr_q       <= addr_q + ADDR_W'(4);
        remaining_q  <= remaining_dec;
        burst_left_q <= burst_left_q - 5'd1;
      end
      if (enter_wait_full) begin
        count_ext_q  <= burst_reload;
        burst_left_q <= burst_reload;
      end
    end
  end

  assign busy           = (state_q != IDLE);
  assign done           = done_q;
  assign fifo_count_ext = count_ext_q;
  assign data_we        = data_req;
  assign data_be        = data_req ? OBI_BE_ALL : 4'h0;
  assign data_addr      = addr_q;
  assign data_wdata     = wdata_q;

`ifdef STALL_CNT_EN
  logic [31:0] stall_q;

  // Counts cycles the arbiter leaves us waiting; saturates instead of
  // wrapping so a long stall never reads back as a short one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (accept) begin
      stall_q <= '0;
    end else if (data_req && !data_gnt && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_mem_writer.sv
// tb_fifo_mem_writer
//
// Directed bench for fifo_mem_writer. A small FIFO model feeds numbered
// words, an OBI slave model grants (optionally after a delay on one chosen
// word) and answers each grant with rvalid one cycle later, and a monitor
// records every granted write. Expected addresses, data and thresholds are
// computed from the test parameters.
module tb_fifo_mem_writer;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int BURST_MAX = 16;
  localparam int LEN_W     = 16;

`ifdef STALL_CNT_EN
  localparam logic [31:0] EXP_STALL_T4 = 32'd5;
`else
  localparam logic [31:0] EXP_STALL_T4 = 32'd0;
`endif

  logic              clk;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  num_words;
  logic              busy;
  logic              done;
  logic [4:0]        fifo_count_ext;
  logic              fifo_pop;
  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic              data_req;
  logic              data_gnt;
  logic              data_rvalid;
  logic              data_we;
  logic [3:0]        data_be;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic [31:0]       stall_cnt;

  int checks;
  int errors;

  fifo_mem_writer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_MAX(BURST_MAX), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .num_words(num_words), .busy(busy), .done(done),
    .fifo_count_ext(fifo_count_ext), .fifo_pop(fifo_pop),
    .fifo_dout(fifo_dout), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .data_req(data_req), .data_gnt(data_gnt), .data_rvalid(data_rvalid),
    .data_we(data_we), .data_be(data_be), .data_addr(data_addr),
    .data_wdata(data_wdata), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Clears all bench models and monitor records between tests.
  logic tb_clear;

  // FIFO model: pushes push_base+k for k = 0..push_total-1, one per cycle
  // while there is room; the registered output updates on a pop.
  logic [DATA_W-1:0] fifo_mem [0:15];
  logic [31:0]       push_base;
  int                push_total;
  int                pushed;
  int                fifo_cnt;
  int                rd_ptr;
  int                wr_ptr;
  logic              fifo_push;

  assign fifo_push  = (pushed < push_total) && (fifo_cnt < 16);
  assign fifo_full  = (fifo_cnt == int'(fifo_count_ext));
  assign fifo_empty = (fifo_cnt == 0);

  always @(posedge clk or posedge rst) begin
    if (rst || tb_clear) begin
      fifo_cnt  <= 0;
      rd_ptr    <= 0;
      wr_ptr    <= 0;
      pushed    <= 0;
      fifo_dout <= '0;
    end else begin
      if (fifo_push) begin
        fifo_mem[wr_ptr] <= push_base + 32'(pushed);
        wr_ptr           <= (wr_ptr + 1) % 16;
        pushed           <= pushed + 1;
      end
      if (fifo_pop) begin
        fifo_dout <= fifo_mem[rd_ptr];
        rd_ptr    <= (rd_ptr + 1) % 16;
      end
      fifo_cnt <= fifo_cnt + (fifo_push ? 1 : 0) - (fifo_pop ? 1 : 0);
    end
  end

  // Memory slave model: grant after delay_cycles waiting cycles on word
  // delay_word (immediately otherwise), rvalid the cycle after the grant.
  int delay_word;
  int delay_cycles;
  int gnt_wait;
  int word_idx;

  assign data_gnt = data_req &&
                    (gnt_wait >= ((word_idx == delay_word) ? delay_cycles : 0));

  always @(posedge clk or posedge rst) begin
    if (rst || tb_clear) begin
      data_rvalid <= 1'b0;
      gnt_wait    <= 0;
      word_idx    <= 0;
    end else begin
      data_rvalid <= data_req && data_gnt;
      gnt_wait    <= (data_req && !data_gnt) ? gnt_wait + 1 : 0;
      if (data_req && data_gnt) begin
        word_idx <= word_idx + 1;
      end
    end
  end

  // Monitor, sampled on the falling edge.
  logic [31:0] wr_addr [$];
  logic [31:0] wr_data [$];
  logic [4:0]  wr_ext  [$];
  int          done_cnt;
  int          pop_cnt;
  int          req_cnt;
  int          pop_empty_cnt;
  int          unstable_cnt;
  logic        prev_wait;
  logic [31:0] prev_addr;
  logic [31:0] prev_wdata;

  always @(negedge clk) begin
    if (tb_clear) begin
      wr_addr.delete();
      wr_data.delete();
      wr_ext.delete();
      done_cnt      <= 0;
      pop_cnt       <= 0;
      req_cnt       <= 0;
      pop_empty_cnt <= 0;
      unstable_cnt  <= 0;
      prev_wait     <= 1'b0;
    end else begin
      if (data_req && data_gnt) begin
        wr_addr.push_back(data_addr);
        wr_data.push_back(data_wdata);
        wr_ext.push_back(fifo_count_ext);
      end
      done_cnt      <= done_cnt + (done ? 1 : 0);
      pop_cnt       <= pop_cnt + (fifo_pop ? 1 : 0);
      req_cnt       <= req_cnt + (data_req ? 1 : 0);
      pop_empty_cnt <= pop_empty_cnt + ((fifo_pop && fifo_empty) ? 1 : 0);
      if (prev_wait && data_req &&
          ((data_addr != prev_addr) || (data_wdata != prev_wdata))) begin
        unstable_cnt <= unstable_cnt + 1;
      end
      prev_wait  <= data_req && !data_gnt;
      prev_addr  <= data_addr;
      prev_wdata <= data_wdata;
    end
  end

  // Single comparison point: counts and reports.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Clears the models, loads the FIFO feed / slave delay, and pulses start.
  // Returns at the falling edge just after start was sampled.
  task automatic applyStimulus(input logic [31:0] base, input int n,
                               input logic [31:0] dbase, input int dword,
                               input int dcyc);
    @(negedge clk);
    tb_clear     = 1'b1;
    push_total   = 0;
    push_base    = dbase;
    delay_word   = dword;
    delay_cycles = dcyc;
    @(negedge clk);
    @(negedge clk);
    tb_clear   = 1'b0;
    push_total = n;
    base_addr  = base;
    num_words  = LEN_W'(n);
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int budget);
    int seen;
    seen = 0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    checkOutput({tag, "_done_seen"}, 32'(seen), 32'd1);
    checkOutput({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic checkTransfer(input string tag, input logic [31:0] base,
                               input int n, input logic [31:0] dbase);
    int cnt;
    int exp_ext;
    cnt = wr_addr.size();
    checkOutput({tag, "_nwrites"}, 32'(cnt), 32'(n));
    for (int i = 0; i < n && i < cnt; i++) begin
      exp_ext = n - 16 * (i / 16);
      if (exp_ext > 16) exp_ext = 16;
      checkOutput($sformatf("%s_addr%0d", tag, i), wr_addr[i], base + 32'(4 * i));
      checkOutput($sformatf("%s_data%0d", tag, i), wr_data[i], dbase + 32'(i));
      checkOutput($sformatf("%s_ext%0d", tag, i), 32'(wr_ext[i]), 32'(exp_ext));
    end
    checkOutput({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    checkOutput({tag, "_pop_empty"}, 32'(pop_empty_cnt), 32'd0);
    checkOutput({tag, "_unstable"}, 32'(unstable_cnt), 32'd0);
    checkOutput({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_pop"}, 32'(fifo_pop), 32'd0);
    checkOutput({tag, "_req"}, 32'(data_req), 32'd0);
    checkOutput({tag, "_we"}, 32'(data_we), 32'd0);
    checkOutput({tag, "_be"}, 32'(data_be), 32'd0);
    checkOutput({tag, "_addr"}, data_addr, 32'd0);
    checkOutput({tag, "_wdata"}, data_wdata, 32'd0);
    checkOutput({tag, "_ext"}, 32'(fifo_count_ext), 32'd16);
    checkOutput({tag, "_stall"}, stall_cnt, 32'd0);
  endtask

  initial begin
    int found;
    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    start        = 1'b0;
    base_addr    = '0;
    num_words    = '0;
    tb_clear     = 1'b1;
    push_total   = 0;
    push_base    = '0;
    delay_word   = -1;
    delay_cycles = 0;
    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] T1 basic 4-word transfer");
    applyStimulus(32'h0000_1000, 4, 32'hA000_0000, -1, 0);
    checkOutput("t1_busy_start", 32'(busy), 32'd1);
    waitDone("t1", 500);
    checkTransfer("t1", 32'h0000_1000, 4, 32'hA000_0000);

    $display("[TB] T2 20 words across two bursts");
    applyStimulus(32'h0000_2000, 20, 32'hB000_0000, -1, 0);
    waitDone("t2", 2000);
    checkTransfer("t2", 32'h0000_2000, 20, 32'hB000_0000);
    if (wr_addr.size() == 20) begin
      checkOutput("t2_last_addr", wr_addr[19], 32'h0000_204C);
    end else begin
      checkOutput("t2_last_addr_missing", 32'(wr_addr.size()), 32'd20);
    end

    $display("[TB] T3 zero-length transfer");
    applyStimulus(32'h0000_3000, 0, 32'h0, -1, 0);
    checkOutput("t3_done_now", 32'(done), 32'd1);
    checkOutput("t3_busy_now", 32'(busy), 32'd0);
    @(negedge clk);
    checkOutput("t3_done_drop", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("t3_pops", 32'(pop_cnt), 32'd0);
    checkOutput("t3_reqs", 32'(req_cnt), 32'd0);
    checkOutput("t3_done_cnt", 32'(done_cnt), 32'd1);

    $display("[TB] T4 grant delayed on word 2");
    applyStimulus(32'h0000_3000, 4, 32'hC000_0000, 2, 5);
    waitDone("t4", 500);
    checkTransfer("t4", 32'h0000_3000, 4, 32'hC000_0000);
    checkOutput("t4_stall_cnt", stall_cnt, EXP_STALL_T4);

    $display("[TB] T5 address wrap");
    applyStimulus(32'hFFFF_FFF8, 4, 32'hD000_0000, -1, 0);
    waitDone("t5", 500);
    checkTransfer("t5", 32'hFFFF_FFF8, 4, 32'hD000_0000);

    $display("[TB] T6 reset in REQ with 3 words left");
    applyStimulus(32'h0000_4000, 8, 32'hE000_0000, -1, 0);
    found = 0;
    for (int i = 0; i < 500; i++) begin
      if (data_req && (data_addr == 32'h0000_4014)) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("t6_reached_req", 32'(found), 32'd1);
    rst = 1'b1;
    #1;
    checkResetOutputs("t6_rst");
    repeat (2) @(negedge clk);
    checkOutput("t6_no_done", 32'(done_cnt), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(32'h0000_5000, 2, 32'hF000_0000, -1, 0);
    waitDone("t6b", 500);
    checkTransfer("t6b", 32'h0000_5000, 2, 32'hF000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
